// File: rtl/lpd_pkg.sv
// Shared types, defaults and the golden compare function for logic_pipe_driver.
package lpd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } lpd_state_t;

    localparam int LPD_LAT = 3;
    localparam int LPD_CW  = 16;

    // What the byte-wise compare pipeline should report for a given word.
    function automatic logic lpd_expect(input logic [31:0] word);
        logic [7:0] a, b, c, d, e, f;
        a = word[7:0];
        b = word[15:8];
        c = word[23:16];
        d = word[31:24];
        e = a | (b & c);
        f = (b & c) ^ (a | d);
        return (e == f);
    endfunction

endpackage

// File: rtl/lpd_tag_pipe.sv
// LAT-deep shift register of {valid, tag} that shadows words travelling through the compare pipeline.
module lpd_tag_pipe
    import lpd_pkg::*;
#(
    parameter int LAT = LPD_LAT,
    parameter int TW  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [TW-1:0] out_tag,
    output logic          empty
);

    logic [LAT-1:0] valid_q;
    logic [TW-1:0]  tag_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= in_tag;
        for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];

    // "empty" means nothing is left once the exit stage is consumed at the next edge.
    generate
        if (LAT == 1) begin : g_single
            assign empty = 1'b1;
        end else begin : g_multi
            assign empty = ~|valid_q[LAT-2:0];
        end
    endgenerate

endmodule

// File: rtl/logic_pipe_driver.sv
// Drives a counter word sequence into the compare pipeline and collects match statistics.
// Optional golden self-check is enabled with the macro LPD_SELF_CHECK_EN.
module logic_pipe_driver
    import lpd_pkg::*;
#(
    parameter int LAT = LPD_LAT,
    parameter int CW  = LPD_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   seed,
    input  logic [31:0]   step,
    input  logic [CW-1:0] num_words,
    input  logic          match_i,
    output logic [31:0]   cnt_o,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [31:0]   first_err_word
);

`ifdef LPD_SELF_CHECK_EN
    localparam int TW = 33;
`else
    localparam int TW = 32;
`endif

    lpd_state_t    state, next_state;
    logic [31:0]   step_q;
    logic [CW-1:0] remaining;
    logic          accept;
    logic          tag_valid;
    logic          pipe_empty;
    logic [TW-1:0] tag_in;
    logic [TW-1:0] tag_out;
    logic [31:0]   tag_word;

    assign accept   = (state == IDLE) && start;
    assign tag_word = tag_out[31:0];

`ifdef LPD_SELF_CHECK_EN
    assign tag_in = {lpd_expect(cnt_o), cnt_o};
`else
    assign tag_in = cnt_o;
`endif

    lpd_tag_pipe #(.LAT(LAT), .TW(TW)) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state == RUN),
        .in_tag    (tag_in),
        .out_valid (tag_valid),
        .out_tag   (tag_out),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) next_state = (num_words == '0) ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (remaining == CW'(1)) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pipe_empty) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The final word is not followed by an increment so cnt_o rests on it after RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o     <= '0;
            step_q    <= '0;
            remaining <= '0;
            match_cnt <= '0;
        end else begin
            if (accept) begin
                step_q    <= step;
                remaining <= num_words;
                match_cnt <= '0;
                if (num_words != '0) cnt_o <= seed;
            end else begin
                if (state == RUN && remaining != CW'(1)) begin
                    cnt_o     <= cnt_o + step_q;
                    remaining <= remaining - CW'(1);
                end
                if (tag_valid && match_i && match_cnt != {CW{1'b1}}) begin
                    match_cnt <= match_cnt + CW'(1);
                end
            end
        end
    end

`ifdef LPD_SELF_CHECK_EN
    logic tag_exp;
    assign tag_exp = tag_out[32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            first_err_word <= '0;
        end else if (accept) begin
            err_cnt        <= '0;
            first_err_word <= '0;
        end else if (tag_valid && (match_i != tag_exp)) begin
            if (err_cnt != {CW{1'b1}}) err_cnt <= err_cnt + CW'(1);
            if (err_cnt == '0)         first_err_word <= tag_word;
        end
    end
`else
    wire unused_tag_word = ^tag_word;
    assign err_cnt        = '0;
    assign first_err_word = '0;
`endif

endmodule

// File: tb/tb_logic_pipe_driver.sv
// Randomised self-checking bench for logic_pipe_driver against a word-list reference model.
module tb_logic_pipe_driver;

    localparam int LAT = 3;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   seed;
    logic [31:0]   step;
    logic [CW-1:0] num_words;
    logic          match_i;
    logic [31:0]   cnt_o;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic [CW-1:0] err_cnt;
    logic [31:0]   first_err_word;

    int passed = 0;
    int total  = 0;

    logic_pipe_driver #(.LAT(LAT), .CW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .seed           (seed),
        .step           (step),
        .num_words      (num_words),
        .match_i        (match_i),
        .cnt_o          (cnt_o),
        .busy           (busy),
        .done           (done),
        .match_cnt      (match_cnt),
        .err_cnt        (err_cnt),
        .first_err_word (first_err_word)
    );

    always #5 clk = ~clk;

    function automatic logic ref_expect(input logic [31:0] w);
        logic [7:0] a, b, c, d;
        a = w[7:0];
        b = w[15:8];
        c = w[23:16];
        d = w[31:24];
        return ((a | (b & c)) == ((b & c) ^ (a | d)));
    endfunction

    // mode 0: ideal pipeline, 1: match_i stuck at 1, 2: random responses
    task automatic run_and_check(input string name, input logic [31:0] s, input logic [31:0] st,
                                 input int n, input int mode);
        logic [31:0] words[$];
        logic        resp[$];
        logic [31:0] w;
        int          exp_match;
        int          exp_err;
        logic [31:0] exp_first;
        int          last;
        w         = s;
        exp_match = 0;
        exp_err   = 0;
        exp_first = '0;
        for (int i = 0; i < n; i++) begin
            logic r;
            words.push_back(w);
            r = (mode == 0) ? ref_expect(w) : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            resp.push_back(r);
            if (r) exp_match++;
`ifdef LPD_SELF_CHECK_EN
            if (r != ref_expect(w)) begin
                if (exp_err == 0) exp_first = w;
                exp_err++;
            end
`endif
            w = w + st;
        end
        last = (n == 0) ? 0 : n + LAT;

        seed      = s;
        step      = st;
        num_words = CW'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c <= last; c++) begin
            start     = 1'($urandom_range(0, 1));
            seed      = $urandom;
            step      = $urandom;
            num_words = CW'($urandom);
            match_i   = (c >= LAT && c - LAT < n) ? resp[c-LAT] : 1'($urandom_range(0, 1));
            if (n > 0) begin
                total++;
                if (cnt_o !== words[(c < n) ? c : n-1])
                    $display("[TB] FAIL %s cnt_o c=%0d: got %h expected %h", name, c, cnt_o, words[(c < n) ? c : n-1]);
                else passed++;
            end
            total++;
            if (busy !== (n > 0 && c < n + LAT))
                $display("[TB] FAIL %s busy c=%0d: got %b expected %b", name, c, busy, (n > 0 && c < n + LAT));
            else passed++;
            total++;
            if (done !== (c == last))
                $display("[TB] FAIL %s done c=%0d: got %b expected %b", name, c, done, (c == last));
            else passed++;
            if (c < last) begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (match_cnt !== CW'(exp_match))
            $display("[TB] FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, exp_match);
        else passed++;
        total++;
        if (err_cnt !== CW'(exp_err))
            $display("[TB] FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
        else passed++;
        total++;
        if (first_err_word !== exp_first)
            $display("[TB] FAIL %s first_err_word: got %h expected %h", name, first_err_word, exp_first);
        else passed++;

        start   = 1'b0;
        match_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== CW'(exp_match))
            $display("[TB] FAIL %s after_done: got done=%b busy=%b match_cnt=%0d expected 0 0 %0d",
                     name, done, busy, match_cnt, exp_match);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        seed      = '0;
        step      = '0;
        num_words = '0;
        match_i   = 1'b0;
        #1;
        total++;
        if ({cnt_o, busy, done, match_cnt, err_cnt, first_err_word} !== '0)
            $display("[TB] FAIL reset_outputs: got cnt=%h busy=%b done=%b mc=%0d ec=%0d few=%h expected all 0",
                     cnt_o, busy, done, match_cnt, err_cnt, first_err_word);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, match_cnt} !== '0)
            $display("[TB] FAIL reset_idle: got busy=%b done=%b mc=%0d expected 0", busy, done, match_cnt);
        else passed++;
    endtask

    task automatic test_count_up();
        run_and_check("count_up", 32'h0000_0000, 32'd1, 4, 0);
    endtask

    task automatic test_byte_mismatch();
        run_and_check("byte_mismatch", 32'h0100_0000, 32'd1, 2, 0);
    endtask

    task automatic test_wrap();
        run_and_check("wrap", 32'hFFFF_FFFF, 32'd1, 2, 0);
    endtask

    task automatic test_zero_words();
        run_and_check("zero_words", 32'h1234_5678, 32'd7, 0, 0);
    endtask

    task automatic test_self_check();
        run_and_check("self_check", 32'h0100_0000, 32'd1, 1, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_and_check("random", $urandom, $urandom, $urandom_range(1, 12), 2);
        end
    endtask

    task automatic test_back_to_back();
        run_and_check("b2b_first", $urandom, 32'd3, 5, 0);
        run_and_check("b2b_second", $urandom, 32'hFFFF_FFFF, 3, 2);
    endtask

    task automatic test_reset_mid_run();
        seed      = 32'h0;
        step      = 32'd1;
        num_words = CW'(8);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            match_i = (c >= LAT);
            @(posedge clk); #1;
        end
        total++;
        if (match_cnt !== CW'(2) || busy !== 1'b1)
            $display("[TB] FAIL mid_run_pre: got mc=%0d busy=%b expected 2 1", match_cnt, busy);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({cnt_o, busy, done, match_cnt, err_cnt, first_err_word} !== '0)
            $display("[TB] FAIL mid_run_reset: got cnt=%h busy=%b done=%b mc=%0d ec=%0d few=%h expected all 0",
                     cnt_o, busy, done, match_cnt, err_cnt, first_err_word);
        else passed++;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("[TB] FAIL mid_run_hold: got done=%b busy=%b expected 0 0", done, busy);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_and_check("after_reset", 32'h0, 32'd1, 8, 0);
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_byte_mismatch();
        test_wrap();
        test_zero_words();
        test_self_check();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "[TB] timeout");
    end

endmodule
